// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the pipelined CPU's cache slice: the machine word, the
// instruction-cache address split and frame layout (sized for the default
// 16-frame icache), and the icache controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default icache geometry: 16 one-word frames.
  localparam int ICACHE_FRAMES = 16;
  localparam int IIDX_W        = $clog2(ICACHE_FRAMES);
  localparam int ITAG_W        = 30 - IIDX_W;

  // Fetch byte address viewed as {tag, index, byte offset}.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  // One cache frame.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage : cpu_types_pkg

// File: rtl/icache.sv
// icache
// Direct-mapped, read-only instruction cache with one-word frames. Hits are
// answered combinationally in the request cycle; a miss issues a single-word
// fill to the memory controller and installs the returned word.
//
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   imemREN, imemaddr  datapath fetch request and byte address
//   ihit, imemload     hit indication and instruction word (0 when no hit)
//   iREN, iaddr        fill request and word address to the controller
//   iwait, iload       controller busy flag and fill data (valid when iwait=0)
module icache
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = 16,
  parameter int IDX_W  = $clog2(FRAMES),
  parameter int TAG_W  = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  icache_state_t state, next_state;

  logic [FRAMES-1:0] valid;
  logic [TAG_W-1:0]  tags [FRAMES];
  word_t             data [FRAMES];
  word_t             miss_addr;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic             fill;

  // Byte offset is architecturally always zero and carries no information.
  logic unused_bytoff;
  assign unused_bytoff = ^imemaddr[1:0];

  assign addr_tag = imemaddr[31:IDX_W+2];
  assign addr_idx = imemaddr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];

  // Lookups are only answered in IDLE, so the in-flight fill word is never
  // forwarded while FETCH is still outstanding.
  assign hit      = imemREN && valid[addr_idx] && (tags[addr_idx] == addr_tag)
                    && (state == IDLE);
  assign ihit     = hit;
  assign imemload = hit ? data[addr_idx] : '0;

  // The fill lands on the cycle the controller drops iwait while we request.
  assign fill = (state == FETCH) && !iwait;

  // NOTE: the next-state block assigns every output a default first, so no
  // path through it leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    iaddr      = '0;
    unique case (state)
      IDLE: begin
        if (imemREN && !hit) next_state = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && imemREN && !hit) miss_addr <= imemaddr;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide
  // whether a frame's contents mean anything.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

endmodule : icache

// File: tb/tb_icache.sv
// tb_icache
// Self-checking bench for icache: a timed memory responder answers fills with
// a configurable number of wait cycles, and a scoreboard queue holds the word
// each fetch must return when ihit is seen.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks   = 0;
  int failures = 0;

  int mem_lat  = 2;
  int wait_cnt = 0;

  logic [31:0] sb_q[$];

  icache #(.FRAMES(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents as seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3C01_0001;
      32'h0000_0044: return 32'hAAAA_0000;
      default:       return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endcase
  endfunction

  // Memory controller: iwait stays high for mem_lat cycles of a request,
  // then drops with the data for the requested address.
  initial begin
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (iREN) begin
        if (wait_cnt < mem_lat) begin
          iwait    = 1'b1;
          iload    = '0;
          wait_cnt = wait_cnt + 1;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
        end
      end else begin
        wait_cnt = 0;
        iwait    = 1'b1;
        iload    = '0;
      end
    end
  end

  // Issue a fetch (caller is 1 time unit after a rising edge) and wait for
  // ihit; checks the fill address while iREN is up, the hit latency, and the
  // returned word against the scoreboard.
  task automatic fetch(input logic [31:0] a, input int exp_lat, input string name);
    int  cyc;
    bit  done;
    logic [31:0] exp_w;
    imemREN  = 1'b1;
    imemaddr = a;
    sb_q.push_back(mem_word(a));
    cyc  = 0;
    done = 0;
    while (!done && cyc < 50) begin
      @(negedge CLK);
      if (ihit) begin
        exp_w = sb_q.pop_front();
        checks++;
        if (imemload !== exp_w) begin
          failures++;
          $display("FAIL %s data: got %h want %h", name, imemload, exp_w);
        end
        checks++;
        if (cyc != exp_lat) begin
          failures++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        checks++;
        if (iREN !== 1'b0) begin
          failures++;
          $display("FAIL %s iREN on hit: got %b want 0", name, iREN);
        end
        done = 1;
      end else if (iREN === 1'b1) begin
        checks++;
        if (iaddr !== a) begin
          failures++;
          $display("FAIL %s iaddr: got %h want %h", name, iaddr, a);
        end
      end
      @(posedge CLK);
      #1;
      if (!done) cyc++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no ihit after %0d cycles", name, cyc);
      void'(sb_q.pop_front());
    end
    imemREN = 1'b0;
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    #12;
    checks++;
    if ({ihit, iREN, iaddr, imemload} !== 66'b0) begin
      failures++;
      $display("FAIL reset outputs: got ihit=%b iREN=%b iaddr=%h imemload=%h want all 0",
               ihit, iREN, iaddr, imemload);
    end
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0, mem_lat + 2, "cold_miss_0x0");
  endtask

  task automatic test_hit();
    fetch(32'h0, 0, "hit_0x0");
  endtask

  task automatic test_conflict();
    fetch(32'h4,  mem_lat + 2, "fill_0x4");
    fetch(32'h44, mem_lat + 2, "evict_0x44");
    fetch(32'h4,  mem_lat + 2, "refill_0x4");
    fetch(32'h44, mem_lat + 2, "refill_0x44");
  endtask

  task automatic test_redirect();
    int cyc;
    imemREN  = 1'b1;
    imemaddr = 32'h10;
    @(posedge CLK);
    #1;
    imemaddr = 32'h20;
    cyc = 0;
    @(negedge CLK);
    while (iREN === 1'b1 && cyc < 50) begin
      checks++;
      if (iaddr !== 32'h10 || ihit !== 1'b0) begin
        failures++;
        $display("FAIL redirect hold: got iaddr=%h ihit=%b want 00000010 0", iaddr, ihit);
      end
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (cyc == 0 || cyc >= 50) begin
      failures++;
      $display("FAIL redirect fetch length: got %0d cycles want %0d", cyc, mem_lat + 1);
    end
    // Back in IDLE with the new address: must miss.
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("FAIL redirect new miss: got ihit=%b want 0", ihit);
    end
    @(negedge CLK);
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h20) begin
      failures++;
      $display("FAIL redirect refetch: got iREN=%b iaddr=%h want 1 00000020", iREN, iaddr);
    end
    @(posedge CLK);
    #1;
    fetch(32'h20, mem_lat, "redirect_0x20_finish");
    fetch(32'h10, 0, "redirect_0x10_hit");
  endtask

  task automatic test_ren_low();
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
        failures++;
        $display("FAIL ren_low: got ihit=%b imemload=%h iREN=%b want 0 0 0",
                 ihit, imemload, iREN);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_fetch();
    mem_lat  = 6;
    imemREN  = 1'b1;
    imemaddr = 32'h30;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    checks++;
    if (iREN !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid setup: got iREN=%b want 1", iREN);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid async drop: got iREN=%b iaddr=%h want 0 0", iREN, iaddr);
    end
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    mem_lat = 2;
    fetch(32'h0,  mem_lat + 2, "post_reset_0x0_miss");
    fetch(32'h30, mem_lat + 2, "post_reset_0x30_miss");
  endtask

  initial begin
    imemREN  = 1'b0;
    imemaddr = '0;
    nRST     = 1'b1;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_redirect();
    test_ren_low();
    test_reset_mid_fetch();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_icache

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache sitting between the pipelined datapath's fetch port and the memory controller's instruction port. It answers the datapath's `imemREN`/`imemaddr` requests with `ihit`/`imemload`. On a miss it issues a single-word fill request (`iREN`/`iaddr`), waits on `iwait`, and installs the returned word. It is the responder end of the datapath's instruction-fetch handshake.

## Interface
Parameters:
- `FRAMES`, 16: number of one-word frames; power of two, at least 2.
- `IDX_W`, `$clog2(FRAMES)`: index width.
- `TAG_W`, `30-IDX_W`: tag width.

Ports:
- `CLK`, in, 1: clock, rising edge.
- `nRST`, in, 1: asynchronous, active-low reset.
- `imemREN`, in, 1: datapath fetch request.
- `imemaddr`, in, 32: fetch byte address; bits [1:0] are always 0.
- `ihit`, out, 1: requested word is valid on `imemload` this cycle.
- `imemload`, out, 32: instruction word.
- `iREN`, out, 1: fill request to the memory controller.
- `iaddr`, out, 32: fill word address.
- `iwait`, in, 1: controller busy. When low while `iREN` is high, `iload` is valid.
- `iload`, in, 32: fill data.

## Operation
- Address split: tag = `imemaddr[31:32-TAG_W]`, index = `imemaddr[IDX_W+1:2]`, offset = `[1:0]` (ignored).
- Frame storage: `valid` (1 bit), `tag` (TAG_W), `data` (32). `valid` is the only state cleared on reset.
- Lookup: `hit = imemREN & valid[idx] & (tag[idx] == addr_tag) & (state == IDLE)`.
  - `ihit = hit`.
  - `imemload = data[idx]` when `hit`, otherwise 0.
- FSM states: IDLE, FETCH.
  - IDLE, when `imemREN` is high and `hit` is low: latch `imemaddr` into `miss_addr` and go to FETCH.
  - IDLE, otherwise: stay in IDLE.
  - FETCH: `iREN=1`, `iaddr=miss_addr`.
  - FETCH, when `iwait=0`: write `data=iload`, `tag`, and `valid=1` to the frame at `miss_addr`'s index; go to IDLE.
  - FETCH, when `iwait=1`: hold.
- Outside FETCH: `iREN=0`, `iaddr=0`.
- A fill always overwrites the indexed frame, whatever that frame's previous valid or tag.
- Redirect mid-fill: if `imemaddr` changes or `imemREN` drops during FETCH, the fill still completes for `miss_addr`. There is no abort. After the fill the cache returns to IDLE and looks up the new address normally.
- `imemREN=0` in IDLE: no state change, `ihit=0`, no fill.
- The cache has no write path and no flush input. Halt is expressed by the datapath dropping `imemREN`.

## Timing
- Reset values:
  - `state`: IDLE.
  - all `valid`: 0.
  - `miss_addr`: 0.
  - `ihit`, `iREN`, `iaddr`, `imemload`: 0.
- Hit latency is 0 cycles: `ihit` and `imemload` are combinational from `imemaddr` in the same cycle.
- Miss sequence, for a memory with N wait cycles (`iwait` high for N cycles, then low):
  - cycle 0: IDLE, miss detected.
  - cycles 1..N+1: FETCH, `iREN` high. The fill is written at the end of cycle N+1.
  - cycle N+2: IDLE, `ihit=1`.
  - Total miss penalty: N+2 cycles.
- There is no bypass of `iload` to `imemload` during FETCH; `ihit` stays low for the whole FETCH.
- `iaddr` is stable throughout FETCH.
- Reset asserted mid-FETCH: return to IDLE immediately. `iREN` drops asynchronously, all frames are invalidated, and the in-flight fill is discarded.

## Structure
- `cpu_types_pkg` holds:
  - `word_t`.
  - `icachef_t`: packed struct `{tag, idx, bytoff}`.
  - `icache_frame_t`: `{valid, tag, data}`.
  - a state enum `icache_state_t {IDLE, FETCH}`.
- Datapath-side ports map onto the `datapath_cache_if` icache modport; memory-side ports map onto the `caches_if` icache modport. The top-level wrapper binds these.
- Single module. The frame array is inline flops; no sub-module.

## Test plan
- Reset, then `imemREN=1`, `imemaddr=0x0`:
  - `ihit=0`; FETCH with `iaddr=0x0`.
  - With `iwait` low after 2 cycles and `iload=0x3C010001`: `ihit=1` and `imemload=0x3C010001` exactly 4 cycles after the request.
- Repeat the fetch of `0x0`: `ihit=1` in the same cycle, `iREN` stays 0.
- Conflict eviction (FRAMES=16):
  - Fill `0x4`, then request `0x44` (same index 1, different tag): miss, fill with `0xAAAA0000`.
  - Then request `0x4` again: miss, `iaddr=0x4`.
- Redirect mid-fill:
  - Miss on `0x10`; while `iwait=1`, change `imemaddr` to `0x20`.
  - `iaddr` stays `0x10`; after the fill completes, a new miss on `0x20` occurs.
  - A later `0x10` request hits.
- `imemREN=0` with a valid-tag address: `ihit=0`, `imemload=0`, `iREN` never asserts.
- Assert `nRST` low during FETCH:
  - `iREN=0` immediately, `state=IDLE`.
  - Re-request of the previously cached `0x0` misses.
